// File: rtl/detectfaces_mul_share_arb.sv
// Round-robin shared 8u x 24s multiplier for the detectFaces feature datapath.
// Results leave in acceptance order, tagged with the issuing requester index.
module detectfaces_mul_share_arb #(
    parameter int N_REQ = 4,
    parameter int LAT   = 2,
    parameter int ID_W  = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [8*N_REQ-1:0]    req_a,
    input  logic [24*N_REQ-1:0]   req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic [23:0]           res_data,
    output logic [2:0]            in_flight
);

    logic [ID_W-1:0] last;
    logic [ID_W-1:0] gnt;
    logic            found;
    logic            en;
    logic            acc;
    logic            hs;
    logic [7:0]      op_a;
    logic [23:0]     op_b;
    logic [23:0]     prod;
    int              j;

    logic [LAT-1:0]  vld;
    logic [ID_W-1:0] id_q  [LAT];
    logic [23:0]     dat_q [LAT];

    assign res_valid = vld[LAT-1];
    assign res_id    = id_q[LAT-1];
    assign res_data  = dat_q[LAT-1];

    assign en = !res_valid || res_ready;
    assign hs = res_valid && res_ready;

    // Search starts just after the last winner; only the winner's operands are muxed.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        op_a  = '0;
        op_b  = '0;
        j     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last) + k) % N_REQ;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                gnt   = ID_W'(j);
                op_a  = req_a[8*j +: 8];
                op_b  = req_b[24*j +: 24];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && en && !ap_rst) begin
            req_ready = N_REQ'(1) << gnt;
        end
    end

    assign acc = |(req_valid & req_ready);

    // Low 24 bits of the signed 33-bit product equal the zero-extended product mod 2^24.
    assign prod = {16'd0, op_a} * op_b;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            last      <= ID_W'(N_REQ - 1);
            vld       <= '0;
            in_flight <= '0;
            for (int i = 0; i < LAT; i++) begin
                id_q[i]  <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            if (acc) begin
                last <= gnt;
            end
            if (en) begin
                vld[0]   <= acc;
                id_q[0]  <= acc ? gnt : '0;
                dat_q[0] <= acc ? prod : '0;
                for (int i = 1; i < LAT; i++) begin
                    vld[i]   <= vld[i-1];
                    id_q[i]  <= id_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
            in_flight <= in_flight + 3'(acc) - 3'(hs);
        end
    end

endmodule

// File: tb/tb_detectfaces_mul_share_arb.sv
// Bench for detectfaces_mul_share_arb: directed scenarios plus a randomized run
// checked against a queue-based model of the shared multiplier.
module tb_detectfaces_mul_share_arb;

    localparam int N    = 4;
    localparam int LAT  = 2;
    localparam int ID_W = 2;

    logic            clk;
    logic            ap_rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [8*N-1:0]  req_a;
    logic [24*N-1:0] req_b;
    logic            res_valid;
    logic            res_ready;
    logic [ID_W-1:0] res_id;
    logic [23:0]     res_data;
    logic [2:0]      in_flight;

    int n_chk;
    int n_fail;

    detectfaces_mul_share_arb #(.N_REQ(N), .LAT(LAT), .ID_W(ID_W)) dut (
        .ap_clk(clk),
        .ap_rst(ap_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_id(res_id),
        .res_data(res_data),
        .in_flight(in_flight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: ops in acceptance order, each with the number of enabled edges it has seen.
    typedef struct {
        int          id;
        logic [23:0] data;
        int          age;
    } op_t;

    op_t          q[$];
    int           last_m = N - 1;
    logic [N-1:0] acc_mask;

    function automatic logic [23:0] prod(input logic [7:0] a, input logic [23:0] b);
        longint p;
        p = longint'(a) * longint'(signed'(b));
        return p[23:0];
    endfunction

    function automatic void meval(output logic mv, output logic men,
                                  output logic [N-1:0] mr, output int mg);
        mv  = (q.size() > 0) && (q[0].age == LAT);
        men = !mv || res_ready;
        mg  = -1;
        for (int k = 1; k <= N; k++) begin
            if (mg < 0 && req_valid[(last_m + k) % N]) mg = (last_m + k) % N;
        end
        mr = '0;
        if (!ap_rst && men && mg >= 0) mr[mg] = 1'b1;
    endfunction

    always @(posedge clk) begin
        logic         mv, men;
        logic [N-1:0] mr;
        int           mg;
        meval(mv, men, mr, mg);
        acc_mask = mr & req_valid;
        if (ap_rst) begin
            q.delete();
            last_m = N - 1;
        end else begin
            if (mv && res_ready) void'(q.pop_front());
            if (men) foreach (q[i]) q[i].age++;
            if (mr != '0) begin
                q.push_back('{mg, prod(req_a[8*mg +: 8], req_b[24*mg +: 24]), 1});
                last_m = mg;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [23:0] b);
        req_a[8*i +: 8]   = a;
        req_b[24*i +: 24] = b;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; req_valid = '1; res_ready = 1'b1;
        step();
        @(negedge clk);
        n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", res_valid); end
        n_chk++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", res_id); end
        n_chk++; if (res_data !== 24'h0) begin n_fail++; $display("FAIL reset_data got %h want 000000", res_data); end
        n_chk++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL reset_inflight got %0d want 0", in_flight); end
        step();
        ap_rst = 1'b0; req_valid = '0;
        step();
    endtask

    task automatic test_single();
        set_req(2, 8'd200, 24'hFFFFFD);
        req_valid = 4'b0100; res_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            n_chk++; if (res_valid !== (c == LAT)) begin n_fail++; $display("FAIL single_valid c%0d got %b want %b", c, res_valid, c == LAT); end
            n_chk++; if (in_flight !== 3'd1) begin n_fail++; $display("FAIL single_inflight c%0d got %0d want 1", c, in_flight); end
            if (c == LAT) begin
                n_chk++; if (res_id !== 2'd2) begin n_fail++; $display("FAIL single_id got %0d want 2", res_id); end
                n_chk++; if (res_data !== 24'hFFFDA8) begin n_fail++; $display("FAIL single_data got %h want fffda8", res_data); end
            end
            step();
        end
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid got %b want 0", res_valid); end
        n_chk++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL single_after_inflight got %0d want 0", in_flight); end
        step();
    endtask

    task automatic test_truncation();
        logic [7:0]  ta [2];
        logic [23:0] tb [2];
        logic [23:0] te [2];
        ta = '{8'd255, 8'd0};
        tb = '{24'h7FFFFF, 24'hFFFFFF};
        te = '{24'h7FFF01, 24'h000000};
        for (int n = 0; n < 2; n++) begin
            set_req(3, ta[n], tb[n]);
            req_valid = 4'b1000; res_ready = 1'b1;
            step();
            req_valid = '0;
            repeat (LAT - 1) step();
            @(negedge clk);
            n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL trunc%0d_valid got %b want 1", n, res_valid); end
            n_chk++; if (res_data !== te[n]) begin n_fail++; $display("FAIL trunc%0d_data got %h want %h", n, res_data, te[n]); end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic [23:0] expd [6];
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 24'($urandom));
        req_valid = '1; res_ready = 1'b1;
        for (int t = 0; t < 6 + LAT; t++) begin
            @(negedge clk);
            if (t < 6) begin
                expd[t] = prod(req_a[8*(t%4) +: 8], req_b[24*(t%4) +: 24]);
                n_chk++; if (req_ready !== 4'(1 << (t % 4))) begin n_fail++; $display("FAIL rr_ready t%0d got %b want %b", t, req_ready, 4'(1 << (t % 4))); end
            end
            if (t >= LAT) begin
                n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid t%0d got %b want 1", t, res_valid); end
                n_chk++; if (res_id !== 2'((t - LAT) % 4)) begin n_fail++; $display("FAIL rr_id t%0d got %0d want %0d", t, res_id, (t - LAT) % 4); end
                n_chk++; if (res_data !== expd[t-LAT]) begin n_fail++; $display("FAIL rr_data t%0d got %h want %h", t, res_data, expd[t-LAT]); end
            end
            step();
            if (t < 6) set_req(t % 4, 8'($urandom), 24'($urandom));
            if (t == 5) req_valid = '0;
        end
        step();
    endtask

    task automatic test_backpressure();
        int          eid [LAT];
        logic [23:0] edat [LAT];
        logic [ID_W-1:0] hid;
        logic [23:0] hdat;
        int          got;
        req_valid = '1; res_ready = 1'b0;
        hid = '0; hdat = '0; got = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (t < LAT) begin
                eid[t]  = (2 + t) % 4;
                edat[t] = prod(req_a[8*eid[t] +: 8], req_b[24*eid[t] +: 24]);
                n_chk++; if (req_ready !== 4'(1 << eid[t])) begin n_fail++; $display("FAIL bp_ready t%0d got %b want %b", t, req_ready, 4'(1 << eid[t])); end
            end else begin
                n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready t%0d got %b want 0000", t, req_ready); end
                n_chk++; if (in_flight !== 3'(LAT)) begin n_fail++; $display("FAIL bp_inflight t%0d got %0d want %0d", t, in_flight, LAT); end
                n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid t%0d got %b want 1", t, res_valid); end
                if (t == LAT) begin
                    hid = res_id; hdat = res_data;
                    n_chk++; if (res_id !== 2'(eid[0])) begin n_fail++; $display("FAIL bp_head_id got %0d want %0d", res_id, eid[0]); end
                end else begin
                    n_chk++; if (res_id !== hid || res_data !== hdat) begin n_fail++; $display("FAIL bp_hold t%0d got %0d/%h want %0d/%h", t, res_id, res_data, hid, hdat); end
                end
            end
            step();
            for (int i = 0; i < N; i++) if (acc_mask[i]) set_req(i, 8'($urandom), 24'($urandom));
        end
        req_valid = '0; res_ready = 1'b1;
        for (int t = 0; t < LAT + 2; t++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                if (got < LAT) begin
                    n_chk++; if (res_id !== 2'(eid[got]) || res_data !== edat[got]) begin n_fail++; $display("FAIL bp_drain%0d got %0d/%h want %0d/%h", got, res_id, res_data, eid[got], edat[got]); end
                end
                got++;
            end
            step();
        end
        n_chk++; if (got !== LAT) begin n_fail++; $display("FAIL bp_drain_count got %0d want %0d", got, LAT); end
        n_chk++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL bp_drain_inflight got %0d want 0", in_flight); end
    endtask

    task automatic test_pointer();
        req_valid = 4'b1000; res_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL ptr_solo t%0d got %b want 1000", t, req_ready); end
            step();
            set_req(3, 8'($urandom), 24'($urandom));
        end
        req_valid = 4'b1001;
        @(negedge clk);
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ptr_first got %b want 0001", req_ready); end
        step();
        @(negedge clk);
        n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL ptr_second got %b want 1000", req_ready); end
        step();
        req_valid = '0;
        repeat (LAT + 2) step();
    endtask

    task automatic test_reset_mid();
        logic [23:0] want;
        int          got;
        got = 0;
        set_req(1, 8'd17, 24'h000111);
        set_req(2, 8'd33, 24'h000222);
        req_valid = 4'b0110; res_ready = 1'b0;
        @(negedge clk);
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_mid_g0 got %b want 0010", req_ready); end
        step();
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        @(negedge clk);
        n_chk++; if (in_flight !== 3'd2) begin n_fail++; $display("FAIL rst_mid_pre_inflight got %0d want 2", in_flight); end
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        set_req(1, 8'd5, 24'h000007);
        want = 24'd35;
        req_valid = 4'b1010; res_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", res_valid); end
        n_chk++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL rst_mid_inflight got %0d want 0", in_flight); end
        n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_mid_grant got %b want 0010", req_ready); end
        step();
        req_valid = '0;
        for (int t = 0; t < LAT + 2; t++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                got++;
                n_chk++; if (res_id !== 2'd1 || res_data !== want) begin n_fail++; $display("FAIL rst_mid_result got %0d/%h want 1/%h", res_id, res_data, want); end
            end
            step();
        end
        n_chk++; if (got !== 1) begin n_fail++; $display("FAIL rst_mid_count got %0d want 1", got); end
    endtask

    task automatic test_random();
        logic         mv, men;
        logic [N-1:0] mr;
        int           mg;
        req_valid = '0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            meval(mv, men, mr, mg);
            n_chk++; if (req_ready !== mr) begin n_fail++; $display("FAIL rnd_ready t%0d got %b want %b", t, req_ready, mr); end
            n_chk++; if (res_valid !== mv) begin n_fail++; $display("FAIL rnd_valid t%0d got %b want %b", t, res_valid, mv); end
            n_chk++; if (in_flight !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_inflight t%0d got %0d want %0d", t, in_flight, q.size()); end
            if (mv) begin
                n_chk++; if (res_id !== 2'(q[0].id) || res_data !== q[0].data) begin n_fail++; $display("FAIL rnd_result t%0d got %0d/%h want %0d/%h", t, res_id, res_data, q[0].id, q[0].data); end
            end
            step();
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    set_req(i, 8'($urandom), 24'($urandom));
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0; res_ready = 1'b1;
        repeat (LAT + 2) step();
        n_chk++; if (in_flight !== 3'd0) begin n_fail++; $display("FAIL rnd_final_inflight got %0d want 0", in_flight); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        ap_rst = 1'b1; req_valid = '0; res_ready = 1'b1;
        req_a = '0; req_b = '0;
        test_reset();
        test_single();
        test_truncation();
        test_round_robin();
        test_backpressure();
        test_pointer();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
